// File: rtl/voq_match_scheduler.sv
// Purpose : sequential 4x4 crossbar scheduler, one ingress visited per cycle with per-ingress round-robin VOQ pick.
// Latency : sched_start at edge T -> PICK over T+1..T+4 -> sched_done high after edge T+4 -> IDLE after edge T+5.
// Backpr. : none; sched_start while busy is dropped, not queued.
// Ports   : clk/reset_n (sync, active-low); sched_start + voq_empty[16] in;
//           busy, sched_done, sched_valid[4], sched_sel[8] (2b egress per ingress), egress_taken[4] out.
module voq_match_scheduler #(
  parameter int PORT_NUM = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sched_start,
  input  logic [15:0] voq_empty,
  output logic        busy,
  output logic        sched_done,
  output logic [3:0]  sched_valid,
  output logic [7:0]  sched_sel,
  output logic [3:0]  egress_taken
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PICK = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      step_q, step_d;
  logic [15:0]     snap_q, snap_d;
  logic [3:0]      valid_q, valid_d;
  logic [3:0][1:0] sel_q, sel_d;
  logic [3:0]      taken_q, taken_d;
  logic [3:0][1:0] voq_ptr_q, voq_ptr_d;
  logic [1:0]      ing_ptr_q, ing_ptr_d;

  // Pick for the ingress visited this cycle
  logic [1:0] visit_ing;
  logic [1:0] cand;
  logic       pick_vld;
  logic [1:0] pick_egr;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      step_q    <= 2'd0;
      snap_q    <= 16'd0;
      valid_q   <= 4'd0;
      sel_q     <= '0;
      taken_q   <= 4'd0;
      voq_ptr_q <= '0;
      ing_ptr_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      snap_q    <= snap_d;
      valid_q   <= valid_d;
      sel_q     <= sel_d;
      taken_q   <= taken_d;
      voq_ptr_q <= voq_ptr_d;
      ing_ptr_q <= ing_ptr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sched_start) state_d = PICK;
      PICK:    if (step_q == 2'd3) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Round-robin scan: first egress at/after the ingress's pointer that is
  // non-empty in the snapshot and not already claimed this round.
  always_comb begin
    visit_ing = ing_ptr_q + step_q;
    cand      = 2'd0;
    pick_vld  = 1'b0;
    pick_egr  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = voq_ptr_q[visit_ing] + 2'(k);
      if (!pick_vld && !snap_q[{visit_ing, cand}] && !taken_q[cand]) begin
        pick_vld = 1'b1;
        pick_egr = cand;
      end
    end
  end

  // Datapath and pointer updates
  always_comb begin
    step_d    = step_q;
    snap_d    = snap_q;
    valid_d   = valid_q;
    sel_d     = sel_q;
    taken_d   = taken_q;
    voq_ptr_d = voq_ptr_q;
    ing_ptr_d = ing_ptr_q;
    case (state_q)
      IDLE: begin
        // Previous round's result stays visible until the next round is accepted
        if (sched_start) begin
          snap_d  = voq_empty;
          valid_d = 4'd0;
          sel_d   = '0;
          taken_d = 4'd0;
          step_d  = 2'd0;
        end
      end
      PICK: begin
        if (pick_vld) begin
          valid_d[visit_ing] = 1'b1;
          sel_d[visit_ing]   = pick_egr;
          taken_d[pick_egr]  = 1'b1;
        end
        step_d = step_q + 2'd1;
      end
      DONE: begin
        // Matched ingresses move their pointer past the egress they just won
        for (int i = 0; i < 4; i++) begin
          if (valid_q[i]) voq_ptr_d[i] = sel_q[i] + 2'd1;
        end
        ing_ptr_d = ing_ptr_q + 2'd1;
      end
      default: ;
    endcase
  end

  // Output logic
  always_comb begin
    busy         = (state_q != IDLE);
    sched_done   = (state_q == DONE);
    sched_valid  = valid_q;
    sched_sel    = sel_q;
    egress_taken = taken_q;
  end

endmodule

// File: tb/tb_voq_match_scheduler.sv
// Purpose : randomized + directed bench for voq_match_scheduler against a round-level reference model.
// Latency : checks sched_done arrives exactly 4 cycles after the first PICK cycle.
// Backpr. : injects dropped starts during PICK/DONE and mid-round voq_empty changes.
module tb_voq_match_scheduler;

  logic        clk;
  logic        reset_n;
  logic        sched_start;
  logic [15:0] voq_empty;
  logic        busy;
  logic        sched_done;
  logic [3:0]  sched_valid;
  logic [7:0]  sched_sel;
  logic [3:0]  egress_taken;

  int checks_cnt;
  int fail_cnt;

  // Reference model state
  int m_vp[4];
  int m_ip;

  voq_match_scheduler #(.PORT_NUM(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sched_start  (sched_start),
    .voq_empty    (voq_empty),
    .busy         (busy),
    .sched_done   (sched_done),
    .sched_valid  (sched_valid),
    .sched_sel    (sched_sel),
    .egress_taken (egress_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_vp[i] = 0;
    m_ip = 0;
  endtask

  // Whole-round matching: visit ingresses in order from m_ip, each takes the
  // first free, non-empty egress counting from its own pointer.
  task automatic model_round(input logic [15:0] e, output logic [3:0] v,
                             output logic [7:0] s, output logic [3:0] t);
    v = 4'd0;
    s = 8'd0;
    t = 4'd0;
    for (int st = 0; st < 4; st++) begin
      int ing;
      ing = (m_ip + st) % 4;
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_vp[ing] + k) % 4;
        if (!v[ing] && e[4*ing+c] == 1'b0 && t[c] == 1'b0) begin
          v[ing]        = 1'b1;
          s[2*ing +: 2] = 2'(c);
          t[c]          = 1'b1;
        end
      end
    end
  endtask

  task automatic model_advance(input logic [3:0] v, input logic [7:0] s);
    for (int i = 0; i < 4; i++) begin
      if (v[i]) m_vp[i] = (int'(s[2*i +: 2]) + 1) % 4;
    end
    m_ip = (m_ip + 1) % 4;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"},  32'(busy),         32'd0);
    chk({tag, "_done"},  32'(sched_done),   32'd0);
    chk({tag, "_valid"}, 32'(sched_valid),  32'd0);
    chk({tag, "_sel"},   32'(sched_sel),    32'd0);
    chk({tag, "_taken"}, 32'(egress_taken), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n     = 1'b0;
    sched_start = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic run_round(input logic [15:0] e, input bit extra, input bit mid);
    logic [3:0] ev;
    logic [7:0] es;
    logic [3:0] et;
    int  n;
    bit  got;
    model_round(e, ev, es, et);
    @(negedge clk);
    sched_start = 1'b1;
    voq_empty   = e;
    @(negedge clk);                // first PICK cycle
    sched_start = 1'b0;
    chk("pick_busy",  32'(busy),         32'd1);
    chk("pick_valid", 32'(sched_valid),  32'd0);
    chk("pick_taken", 32'(egress_taken), 32'd0);
    if (extra) sched_start = 1'b1;
    if (mid) voq_empty = 16'($urandom);
    got = 1'b0;
    n   = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      sched_start = 1'b0;
      if (mid) voq_empty = 16'($urandom);
      n = i;
      if (sched_done) begin
        got = 1'b1;
        break;
      end
    end
    if (got) chk("done_latency", 32'(n), 32'd4);
    else     chk("done_timeout", 32'd0, 32'd1);
    chk("done_busy",  32'(busy),         32'd1);
    chk("done_valid", 32'(sched_valid),  32'(ev));
    chk("done_sel",   32'(sched_sel),    32'(es));
    chk("done_taken", 32'(egress_taken), 32'(et));
    if (extra) sched_start = 1'b1;  // arrives in DONE, must be dropped
    @(negedge clk);
    sched_start = 1'b0;
    chk("post_busy",  32'(busy),       32'd0);
    chk("post_done",  32'(sched_done), 32'd0);
    chk("hold_sel",   32'(sched_sel),  32'(es));
    model_advance(ev, es);
  endtask

  task automatic reset_mid_round(input logic [15:0] e);
    int dones;
    @(negedge clk);
    sched_start = 1'b1;
    voq_empty   = e;
    @(negedge clk);                // PICK step 0
    sched_start = 1'b0;
    @(negedge clk);                // PICK step 1
    @(negedge clk);                // PICK step 2
    reset_n = 1'b0;
    @(negedge clk);
    check_idle_zero("midrst");
    reset_n = 1'b1;
    model_reset();
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (sched_done) dones++;
    end
    chk("midrst_no_done", 32'(dones), 32'd0);
  endtask

  initial begin
    checks_cnt  = 0;
    fail_cnt    = 0;
    reset_n     = 1'b0;
    sched_start = 1'b0;
    voq_empty   = 16'hFFFF;
    model_reset();

    do_reset();
    run_round(16'hFFFF, 1'b0, 1'b0);   // all empty: no matches, ingress pointer advances
    run_round(16'h0000, 1'b0, 1'b0);   // visit order starts at ingress 1

    do_reset();
    run_round(16'h0000, 1'b0, 1'b0);   // identity matching
    run_round(16'h0000, 1'b0, 1'b0);   // rotated pointers

    do_reset();
    run_round(16'hBBBB, 1'b0, 1'b0);   // all contend for egress 2: ingress 0 wins
    run_round(16'hBBBB, 1'b0, 1'b0);   // then ingress 1 wins

    run_round(16'h1248, 1'b1, 1'b1);   // dropped starts + mid-round input changes

    reset_mid_round(16'h0000);
    run_round(16'h0000, 1'b0, 1'b0);   // behaves as first round after reset

    for (int r = 0; r < 40; r++) begin
      logic [15:0] e;
      e = 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 9) == 0) e = 16'hFFFF;
      if ($urandom_range(0, 9) == 1) e = ~(16'($urandom) & 16'($urandom));
      run_round(e, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
